// File: rtl/mioc_wait.sv
// rtl/mioc_wait.sv - CPU data-memory router to RAM or IO channels with ready handshake, stall, timeout and bus error
module mioc_wait #(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int                NUM_IO       = 4,
    parameter logic [ADDR_W-1:0] IO_BASE      = 32'hFFFF_0000,
    parameter int                IO_SPAN_LOG2 = 8,
    parameter int                TIMEOUT      = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memCe,
    input  logic                     memWr,
    input  logic [ADDR_W-1:0]        memAddr,
    input  logic [DATA_W-1:0]        wtData,
    output logic [DATA_W-1:0]        rdData,
    output logic                     stall,
    output logic                     busErr,
    output logic                     ramCe,
    output logic                     ramWe,
    output logic [ADDR_W-1:0]        ramAddr,
    output logic [DATA_W-1:0]        ramWtData,
    input  logic [DATA_W-1:0]        ramRdData,
    input  logic                     ramRdy,
    output logic [NUM_IO-1:0]        ioCe,
    output logic                     ioWe,
    output logic [ADDR_W-1:0]        ioAddr,
    output logic [DATA_W-1:0]        ioWtData,
    input  logic [NUM_IO*DATA_W-1:0] ioRdData,
    input  logic [NUM_IO-1:0]        ioRdy
);

    localparam int CF_W  = 16 - IO_SPAN_LOG2;
    localparam int CH_W  = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic              io_q, io_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              io_hit;
    logic              unmapped;
    logic [CF_W-1:0]   chan_full;
    logic              rdy_sel;
    logic [DATA_W-1:0] rd_sel;
    logic              acc;

    // Address decode of the live CPU request; only consulted in IDLE
    always_comb begin
        io_hit    = (memAddr[ADDR_W-1:16] == IO_BASE[ADDR_W-1:16]);
        chan_full = memAddr[15:IO_SPAN_LOG2];
        unmapped  = io_hit && (int'(chan_full) >= NUM_IO);
    end

    // Pick ready and read data of the latched target only; all other targets are ignored
    always_comb begin
        rdy_sel = ramRdy;
        rd_sel  = ramRdData;
        if (io_q) begin
            rdy_sel = 1'b0;
            rd_sel  = '0;
            for (int k = 0; k < NUM_IO; k++) begin
                if (chan_q == CH_W'(k)) begin
                    rdy_sel = ioRdy[k];
                    rd_sel  = ioRdData[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Access sequencing: latch request in IDLE, wait for ready or timeout in ACC
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        io_d    = io_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (memCe) begin
                    addr_d  = memAddr;
                    wdata_d = wtData;
                    wr_d    = memWr;
                    io_d    = io_hit;
                    chan_d  = CH_W'(chan_full);
                    cnt_d   = '0;
                    state_d = unmapped ? S_ERR : S_ACC;
                end
            end
            S_ACC: begin
                if (rdy_sel) begin
                    rdata_d = wr_q ? '0 : rd_sel;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latch registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            io_q    <= 1'b0;
            chan_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            io_q    <= io_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
        end
    end

    // Target strobes come from latched state only, so they are exclusive and stable during ACC
    always_comb begin
        acc       = (state_q == S_ACC);
        ramCe     = acc && !io_q;
        ramWe     = acc && !io_q && wr_q;
        ramAddr   = addr_q;
        ramWtData = wdata_q;
        ioWe      = acc && io_q && wr_q;
        ioAddr    = addr_q;
        ioWtData  = wdata_q;
        ioCe      = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            ioCe[k] = acc && io_q && (chan_q == CH_W'(k));
        end
    end

    // CPU-side status; stall is gated by reset so it drops without a clock edge
    always_comb begin
        stall  = rst && memCe && ((state_q == S_IDLE) || (state_q == S_ACC));
        busErr = (state_q == S_ERR);
        rdData = (state_q == S_DONE) ? rdata_q : '0;
    end

endmodule
